cdm_err_profiler: RTL and testbench
===================================

# cdm_err_profiler

On-chip error characterisation engine for the 16x16 carry-disregard approximate multipliers. It drives pseudo-random operand pairs into an externally instantiated approximate multiplier and compares each approximate result with an exact product computed internally. It accumulates error statistics (error count, sum and maximum of error distance) over a programmable number of samples and reports them with a start/done handshake. This replaces the software post-processing of simulation dumps, and the same block can profile any `cdm16_*` variant in silicon or on FPGA.

## Interface
- `W`, 16: operand width; the product width is 2W.
- `CNT_W`, 20: sample counter width; the maximum run is 2^CNT_W − 1 samples.
- `SEED_A`, 16'hACE1: reset/start seed of the operand-A LFSR; must be non-zero.
- `SEED_B`, 16'h1D87: reset/start seed of the operand-B LFSR; must be non-zero.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `num_samples` in CNT_W: run length; sampled together with `start`.
- `mul_a` out W: operand A to the approximate multiplier.
- `mul_b` out W: operand B to the approximate multiplier.
- `mul_r` in 2W: combinational result R from the approximate multiplier.
- `busy` out 1: high while a run is in progress.
- `done` out 1: level signal; high from run completion until the next accepted `start` or reset.
- `err_count` out CNT_W: number of samples with `mul_r` ≠ exact product.
- `sum_ed` out CNT_W+2W: sum of |exact − approx| over the run.
- `max_ed` out 2W: maximum |exact − approx| over the run.

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE. DONE accepts `start` and goes back to RUN.
- Accepted `start`:
  - latch `num_samples`;
  - load both LFSRs with their seeds;
  - clear all statistics and the `done` signal.
- `start` while `busy` is high is ignored.
- `num_samples` = 0: skip RUN and DRAIN and go to DONE on the next edge with all statistics zero.
- RUN: one sample is issued per cycle. `mul_a` and `mul_b` come directly from the LFSR registers. Both LFSRs advance each RUN cycle.
- LFSRs: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400. They shift right and XOR the mask when the output bit is 1.
- Pipeline:
  - Stage 1 registers `mul_r`, the exact product `mul_a*mul_b` (2W, unsigned) and a valid bit.
  - Stage 2 computes ED = |exact − approx| (unsigned, 2W). It increments `err_count` if ED ≠ 0, adds ED to `sum_ed`, and updates `max_ed` if ED > `max_ed`.
- DRAIN: wait until stage 2 holds no valid sample, then go to DONE.
- Statistics hold their values in DONE and IDLE.
- `sum_ed` cannot overflow, because its width covers (2^CNT_W−1)·(2^2W−1).
- `mul_a` and `mul_b` hold their last value outside RUN.

## Timing
- Reset values:
  - state IDLE;
  - `busy` = 0, `done` = 0;
  - `err_count`, `sum_ed`, `max_ed` = 0;
  - LFSRs = seeds, so `mul_a` = SEED_A and `mul_b` = SEED_B.
- Let `start` be accepted at edge E0 with N ≥ 1:
  - `busy` is high from E0.
  - Sample k (0-based) is presented after E0+k, captured at E0+k+1 and accumulated at E0+k+2.
  - `done` rises and `busy` falls at E0+N+2; final statistics are valid in that same cycle.
- N = 0: `done` is high after E0+1; `busy` pulses high for that one cycle only.
- `start` accepted in DONE: `done` falls at the same edge E0 and a new run begins, back-to-back.
- Reset mid-run: all state returns to reset values immediately; any partial statistics are discarded.
- The approximate multiplier is combinational and must meet one clock period from `mul_a`/`mul_b` to `mul_r`.

## Structure
- Shared package `cdm_pkg`: `W`, the LFSR mask 16'hB400, default seeds, and the state enum `{IDLE, RUN, DRAIN, DONE}`.
- One natural sub-module, `cdm_lfsr16`: seedable Galois LFSR with `load` and `step` inputs. The profiler instantiates it twice.
- The approximate multiplier is instantiated outside the block by the integrating top, so that any variant can be profiled.

## Test plan
- Exact multiplier connected (`mul_r` = `mul_a*mul_b`), N = 1000 → `err_count` = 0, `sum_ed` = 0, `max_ed` = 0, `done` at E0+1002.
- Mock `mul_r` = exact with bit 0 cleared, N = 1 → first pair is 0xACE1·0x1D87 = 334538663 (odd), so `err_count` = 1, `sum_ed` = 1, `max_ed` = 1.
- Mock `mul_r` = exact ^ 32'h100, N = 100 → `err_count` = 100, `sum_ed` = 25600, `max_ed` = 256.
- N = 0 → `done` after E0+1; all statistics 0; `mul_a` = 16'hACE1.
- `start` pulsed mid-run → ignored, and statistics match an uninterrupted run. `start` in DONE → statistics cleared, and the operand sequence repeats from the seeds.
- Assert `rst` at cycle 50 of a 100-sample run → outputs return to reset values immediately. A subsequent run gives the same results as a fresh run.

Source files
------------

// File: rtl/cdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdm_pkg
//  Description : Shared constants and types for the carry-disregard
//                multiplier error profiler (operand width, LFSR mask,
//                default seeds, profiler state encoding).
//  Revision    : 1.0  initial release
// ============================================================================
package cdm_pkg;

  localparam int          W           = 16;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [15:0] SEED_A_DEF  = 16'hACE1;
  localparam logic [15:0] SEED_B_DEF  = 16'h1D87;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cdm_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : cdm_lfsr16
//  Description : Seedable 16-bit right-shifting Galois LFSR
//                (x^16+x^14+x^13+x^11+1). load has priority over step.
//  Revision    : 1.0  initial release
// ============================================================================
module cdm_lfsr16
  import cdm_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_A_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value: reseed on load, otherwise shift right and fold in the mask.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (step_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    end
  end

  // State register; reset returns the generator to its seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/cdm_err_profiler.sv
`default_nettype none
// ============================================================================
//  Module      : cdm_err_profiler
//  Description : Drives pseudo-random operand pairs into an external
//                approximate multiplier, compares against the exact product
//                and accumulates error count, sum and max of error distance.
//  Revision    : 1.0  initial release
// ============================================================================
module cdm_err_profiler
  import cdm_pkg::*;
#(
  parameter int          W      = cdm_pkg::W,
  parameter int          CNT_W  = 20,
  parameter logic [15:0] SEED_A = SEED_A_DEF,
  parameter logic [15:0] SEED_B = SEED_B_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_samples,
  output logic [W-1:0]           mul_a,
  output logic [W-1:0]           mul_b,
  input  logic [2*W-1:0]         mul_r,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W+2*W-1:0]   sum_ed,
  output logic [2*W-1:0]         max_ed
);

  localparam int PW    = 2 * W;
  localparam int SUM_W = CNT_W + PW;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              s1_valid_q;
  logic [PW-1:0]     s1_approx_q;
  logic [PW-1:0]     s1_exact_q;
  logic [CNT_W-1:0]  err_q;
  logic [SUM_W-1:0]  sum_q;
  logic [PW-1:0]     max_q;

  logic              accept;
  logic              issue;
  logic [PW-1:0]     exact;
  logic [PW-1:0]     ed;
  logic [15:0]       lfsr_a;
  logic [15:0]       lfsr_b;

  // start is only honoured while no run is in flight; a zero-length run
  // passes through RUN for one cycle without issuing anything.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign issue  = (state_q == RUN) && (n_q != '0);

  cdm_lfsr16 #(.SEED(SEED_A)) u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .step_i  (issue),
    .value_o (lfsr_a)
  );

  cdm_lfsr16 #(.SEED(SEED_B)) u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .step_i  (issue),
    .value_o (lfsr_b)
  );

  assign mul_a = lfsr_a[W-1:0];
  assign mul_b = lfsr_b[W-1:0];
  assign exact = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

  // Next-state logic for the run sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (n_q == '0) begin
          state_d = DONE;
        end else if (cnt_q == (n_q - CNT_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, latched run length and issued-sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        n_q   <= num_samples;
        cnt_q <= '0;
      end else if (issue) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage 1: capture the approximate and exact products of the issued pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_approx_q <= '0;
      s1_exact_q  <= '0;
    end else begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_approx_q <= mul_r;
        s1_exact_q  <= exact;
      end
    end
  end

  assign ed = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                          : (s1_approx_q - s1_exact_q);

  // Stage 2: fold the error distance into the statistics; cleared on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else if (accept) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else if (s1_valid_q) begin
      if (ed != '0) err_q <= err_q + CNT_W'(1);
      sum_q <= sum_q + SUM_W'(ed);
      if (ed > max_q) max_q <= ed;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign err_count = err_q;
  assign sum_ed    = sum_q;
  assign max_ed    = max_q;

endmodule
`default_nettype wire

// File: tb/tb_cdm_err_profiler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdm_err_profiler
//  Description : Directed self-checking bench for cdm_err_profiler with a
//                mock approximate multiplier selectable per test.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdm_err_profiler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] num_samples;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_r;
  logic        busy;
  logic        done;
  logic [19:0] err_count;
  logic [51:0] sum_ed;
  logic [31:0] max_ed;

  int          mode;
  logic [31:0] exact_p;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          edges;

  cdm_err_profiler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_r       (mul_r),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed)
  );

  always #5 clk = ~clk;

  // Mock multiplier: 0 exact, 1 exact with bit 0 cleared, 2 exact ^ 0x100.
  always_comb begin
    exact_p = {16'h0, mul_a} * {16'h0, mul_b};
    mul_r   = exact_p;
    case (mode)
      1:       mul_r = exact_p & 32'hFFFF_FFFE;
      2:       mul_r = exact_p ^ 32'h0000_0100;
      default: mul_r = exact_p;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x, input int n);
    logic [15:0] v;
    v = x;
    for (int i = 0; i < n; i++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    return v;
  endfunction

  // Returns just after edge E0 (the edge that accepts start).
  task automatic start_run(input logic [19:0] n);
    @(negedge clk);
    start       = 1'b1;
    num_samples = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cnt);
    cnt = 0;
    while (!done && cnt < bound) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic check_stats(input string tag, input logic [19:0] e,
                             input logic [51:0] s, input logic [31:0] m);
    check({tag, "_err"}, 64'(err_count), 64'(e));
    check({tag, "_sum"}, 64'(sum_ed), 64'(s));
    check({tag, "_max"}, 64'(max_ed), 64'(m));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = '0;
    mode        = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_stats("rst", 20'd0, 52'd0, 32'd0);
    check("rst_a", 64'(mul_a), 64'hACE1);
    check("rst_b", 64'(mul_b), 64'h1D87);

    // Exact multiplier, 1000 samples
    mode = 0;
    start_run(20'd1000);
    check("t1_busy_e0", 64'(busy), 64'd1);
    wait_done(1100, edges);
    check("t1_latency", 64'(edges), 64'd1002);
    check("t1_busy_end", 64'(busy), 64'd0);
    check_stats("t1", 20'd0, 52'd0, 32'd0);
    check("t1_a_end", 64'(mul_a), 64'(lfsr_adv(16'hACE1, 1000)));
    check("t1_b_end", 64'(mul_b), 64'(lfsr_adv(16'h1D87, 1000)));

    // Bit 0 cleared, single sample (first product is odd)
    mode = 1;
    start_run(20'd1);
    check("t2_done_e0", 64'(done), 64'd0);
    wait_done(20, edges);
    check("t2_latency", 64'(edges), 64'd3);
    check_stats("t2", 20'd1, 52'd1, 32'd1);

    // Bit 8 flipped, 100 samples; check the accumulation timing too
    mode = 2;
    start_run(20'd100);
    check("t3_err_e0", 64'(err_count), 64'd0);
    @(posedge clk); #1;
    check("t3_err_e1", 64'(err_count), 64'd0);
    check("t3_a_e1", 64'(mul_a), 64'(lfsr_adv(16'hACE1, 1)));
    @(posedge clk); #1;
    check("t3_err_e2", 64'(err_count), 64'd1);
    wait_done(200, edges);
    check("t3_latency", 64'(edges + 2), 64'd102);
    check_stats("t3", 20'd100, 52'd25600, 32'd256);

    // Zero-length run started from DONE
    start_run(20'd0);
    check("t4_busy_e0", 64'(busy), 64'd1);
    check("t4_done_e0", 64'(done), 64'd0);
    check_stats("t4_e0", 20'd0, 52'd0, 32'd0);
    wait_done(10, edges);
    check("t4_latency", 64'(edges), 64'd1);
    check("t4_busy_end", 64'(busy), 64'd0);
    check_stats("t4", 20'd0, 52'd0, 32'd0);
    check("t4_a", 64'(mul_a), 64'hACE1);
    check("t4_b", 64'(mul_b), 64'h1D87);

    // start pulsed mid-run must be ignored
    start_run(20'd100);
    repeat (20) @(posedge clk);
    @(negedge clk);
    start       = 1'b1;
    num_samples = 20'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_busy_mid", 64'(busy), 64'd1);
    wait_done(200, edges);
    check("t5_latency", 64'(edges + 21), 64'd102);
    check_stats("t5", 20'd100, 52'd25600, 32'd256);

    // Reset at cycle 50 of a 100-sample run
    start_run(20'd100);
    repeat (50) @(posedge clk);
    #1;
    check("t6_err_pre", 64'(err_count), 64'd49);
    rst = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check_stats("t6", 20'd0, 52'd0, 32'd0);
    check("t6_a", 64'(mul_a), 64'hACE1);
    check("t6_b", 64'(mul_b), 64'h1D87);
    @(negedge clk);
    rst = 1'b0;
    start_run(20'd100);
    wait_done(200, edges);
    check("t7_latency", 64'(edges), 64'd102);
    check_stats("t7", 20'd100, 52'd25600, 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
